// File: rtl/exu_longp_wbck_sched.sv
// Long-pipe write-back scheduler.
// Long-pipe units (LSU, MULDIV, CGRA) can complete out of order relative to
// OITF allocation. Each requester has a one-entry completion buffer. A buffered
// completion is released only when its itag equals the OITF retire pointer, so
// completions leave strictly in program order. The released completion retires
// the OITF entry that cycle and is presented one cycle later on a registered
// write-back or exception port.
module exu_longp_wbck_sched #(
    parameter int N_REQ   = 3,
    parameter int ITAG_W  = 2,
    parameter int RFIDX_W = 5,
    parameter int XLEN    = 32,
    parameter int PC_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    // completions from the long-pipe units, one slice per requester
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ITAG_W-1:0]   req_itag,
    input  logic [N_REQ*XLEN-1:0]     req_wdat,
    input  logic [N_REQ-1:0]          req_err,

    // oldest OITF entry
    input  logic                      oitf_empty,
    input  logic [ITAG_W-1:0]         oitf_ret_ptr,
    input  logic [RFIDX_W-1:0]        oitf_ret_rdidx,
    input  logic                      oitf_ret_rdwen,
    input  logic                      oitf_ret_rdfpu,
    input  logic [PC_W-1:0]           oitf_ret_pc,
    output logic                      oitf_ret_ena,

    // regfile write-back port
    output logic                      wbck_valid,
    input  logic                      wbck_ready,
    output logic [XLEN-1:0]           wbck_wdat,
    output logic [RFIDX_W-1:0]        wbck_rdidx,
    output logic                      wbck_rdfpu,

    // long-pipe exception port
    output logic                      excp_valid,
    input  logic                      excp_ready,
    output logic [PC_W-1:0]           excp_pc
);

    // Output stage: idle, holding a write-back, or holding an exception.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WBCK = 2'd1,
        ST_EXCP = 2'd2
    } state_e;

    state_e               state_q, state_d;

    // Per-requester completion buffers
    logic [N_REQ-1:0]     buf_vld_q, buf_vld_d;
    logic [ITAG_W-1:0]    buf_itag_q [N_REQ];
    logic [XLEN-1:0]      buf_wdat_q [N_REQ];
    logic [N_REQ-1:0]     buf_err_q;

    // Registered output payload
    logic [XLEN-1:0]      wbck_wdat_q;
    logic [RFIDX_W-1:0]   wbck_rdidx_q;
    logic                 wbck_rdfpu_q;
    logic [PC_W-1:0]      excp_pc_q;

    logic [N_REQ-1:0]     match;
    logic [N_REQ-1:0]     win_oh;
    logic [XLEN-1:0]      win_wdat;
    logic                 win_err;
    logic                 can_take;
    logic                 take;
    logic [N_REQ-1:0]     pop;
    logic [N_REQ-1:0]     cap;

    // Compare every valid buffer against the oldest OITF entry.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first; a path that leaves it unassigned would infer a latch.
        match = '0;
        for (int i = 0; i < N_REQ; i++) begin
            match[i] = buf_vld_q[i]
                     & (buf_itag_q[i] == oitf_ret_ptr)
                     & ~oitf_empty;
        end
    end

    // Isolate the lowest-index match; several matches cannot happen with a
    // well-behaved OITF, this only keeps the choice deterministic.
    assign win_oh  = match & (~match + N_REQ'(1));
    assign win_err = |(win_oh & buf_err_q);

    // Select the winning buffer's result data.
    always_comb begin
        win_wdat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_wdat = win_wdat | buf_wdat_q[i];
            end
        end
    end

    // A new completion may enter the output stage when it is empty or when the
    // held write-back is being accepted this cycle; an exception blocks it.
    assign can_take     = (state_q == ST_IDLE) | ((state_q == ST_WBCK) & wbck_ready);
    assign take         = can_take & (|match) & ~flush & ~rst;
    assign pop          = win_oh & {N_REQ{take}};
    assign oitf_ret_ena = take;

    // A buffer is free when empty or when it is being drained this cycle.
    assign req_ready = (~buf_vld_q | pop) & {N_REQ{~flush}};
    assign cap       = req_valid & req_ready;
    assign buf_vld_d = (buf_vld_q & ~pop) | cap;

    // Next state of the output stage.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_WBCK: begin
                if ((state_q == ST_WBCK) && wbck_ready) begin
                    state_d = ST_IDLE;
                end
                if (take) begin
                    if (win_err) begin
                        state_d = ST_EXCP;
                    end else if (oitf_ret_rdwen) begin
                        state_d = ST_WBCK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EXCP: begin
                if (excp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and output payload; reset beats flush, flush beats update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_vld_q    <= '0;
            wbck_wdat_q  <= '0;
            wbck_rdidx_q <= '0;
            wbck_rdfpu_q <= 1'b0;
            excp_pc_q    <= '0;
        end else if (flush) begin
            state_q      <= ST_IDLE;
            buf_vld_q    <= '0;
            wbck_wdat_q  <= '0;
            wbck_rdidx_q <= '0;
            wbck_rdfpu_q <= 1'b0;
            excp_pc_q    <= '0;
        end else begin
            state_q   <= state_d;
            buf_vld_q <= buf_vld_d;
            if (take) begin
                wbck_wdat_q  <= win_wdat;
                wbck_rdidx_q <= oitf_ret_rdidx;
                wbck_rdfpu_q <= oitf_ret_rdfpu;
                excp_pc_q    <= oitf_ret_pc;
            end
        end
    end

    // Buffer payload capture on each accepted completion.
    always_ff @(posedge clk) begin
        // NOTE: the payload needs no reset; it is only looked at while the
        // matching buf_vld_q bit is set, and that bit is reset.
        for (int i = 0; i < N_REQ; i++) begin
            if (cap[i]) begin
                buf_itag_q[i] <= req_itag[i*ITAG_W +: ITAG_W];
                buf_wdat_q[i] <= req_wdat[i*XLEN +: XLEN];
                buf_err_q[i]  <= req_err[i];
            end
        end
    end

    assign wbck_valid = (state_q == ST_WBCK);
    assign excp_valid = (state_q == ST_EXCP);
    assign wbck_wdat  = wbck_wdat_q;
    assign wbck_rdidx = wbck_rdidx_q;
    assign wbck_rdfpu = wbck_rdfpu_q;
    assign excp_pc    = excp_pc_q;

    // Retire pulses never fire against an empty OITF.
    assert property (@(posedge clk) disable iff (rst) oitf_ret_ena |-> !oitf_empty);

    // A write-back stays put until it is accepted (a flush may drop it).
    assert property (@(posedge clk) disable iff (rst)
        (wbck_valid && !wbck_ready && !flush) |=> (wbck_valid && $stable(wbck_wdat)));

endmodule
